burst_ram_master: RTL

BURST_RAM_MASTER -- requirements
Module: burst_ram_master

---
 rtl/burst_ram_master_if.sv | 61 ++++++
 rtl/burst_ram_master.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/burst_ram_master_if.sv
// burst_ram_master_if
//   Groups the command, write-data, read-data and RAM-port signals of
//   burst_ram_master into one bundle.
//
//   Handshake rule for every valid/ready pair (cmd, wr, rd): a transfer
//   happens on a rising clk edge where valid and ready are both high. Once
//   valid is raised, the source holds it and its payload stable until that
//   edge. ready may change in any cycle and may depend on valid.
//
//   Signals:
//     cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len : burst command
//     wr_valid/wr_ready/wr_data                      : write beats in
//     rd_valid/rd_ready/rd_data                      : read beats out
//     ram_addr/ram_wdata/ram_we/ram_q                : one synchronous RAM port
//     busy                                           : master not idle
//     cmd_err  (BRM_WRAP_CHK_EN only)                : rejected-command pulse
//   Modports: master (burst_ram_master), slave (environment side).
interface burst_ram_master_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [3:0]        cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;
    logic              busy;
`ifdef BRM_WRAP_CHK_EN
    logic              cmd_err;
`endif

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data, rd_ready, ram_q,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output ram_addr, ram_wdata, ram_we, busy
`ifdef BRM_WRAP_CHK_EN
        , output cmd_err
`endif
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data, rd_ready, ram_q,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  ram_addr, ram_wdata, ram_we, busy
`ifdef BRM_WRAP_CHK_EN
        , input cmd_err
`endif
    );
endinterface

// File: rtl/burst_ram_master.sv
// burst_ram_master
//   Executes 1..16 beat write or read bursts against one synchronous RAM
//   port (read data appears one clk after the address). Read beats go
//   through a 2-entry FIFO guarded by a credit counter so that no beat is
//   ever dropped or duplicated, whatever the rd_ready pattern, while still
//   sustaining one beat per cycle when rd_ready stays high.
//
//   Ports:
//     clk      : single clock, rising edge
//     rst      : synchronous, active-high reset
//     bus      : burst_ram_master_if.master (command, write, read, RAM port)
//     state_o  : current FSM state (0 IDLE, 1 WRITE, 2 READ, 3 DRAIN)
//
//   Build option: define BRM_WRAP_CHK_EN to reject commands whose burst
//   would run past the top address; such a command is accepted, not
//   executed, and answered by a one-cycle cmd_err pulse. Without the macro
//   bursts simply wrap modulo 2^ADDR_W.
module burst_ram_master #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    burst_ram_master_if.master bus,
    output logic [1:0]         state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] fifo_q [2];
    logic              wptr_q, wptr_d;
    logic              rptr_q, rptr_d;
    logic [1:0]        count_q, count_d;
    logic              push, pop, credit_ok;
`ifdef BRM_WRAP_CHK_EN
    logic              cmd_err_q, cmd_err_d;
    logic [ADDR_W:0]   end_addr;
    logic              crossing;
`endif

    // A read issued last cycle returns on ram_q now and is always pushed.
    assign push = inflight_q;
    assign pop  = (count_q != 2'd0) && bus.rd_ready;

    // Slots already owned (stored + returning) minus the slot freed by this
    // cycle's pop must leave room for one more read.
    assign credit_ok = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

    assign count_d = count_q + {1'b0, push} - {1'b0, pop};
    assign wptr_d  = wptr_q ^ push;
    assign rptr_d  = rptr_q ^ pop;

`ifdef BRM_WRAP_CHK_EN
    // Carry out of the last-beat address means the burst passes the top.
    assign end_addr = {1'b0, bus.cmd_addr} + {{(ADDR_W-3){1'b0}}, bus.cmd_len};
    assign crossing = end_addr[ADDR_W];
    assign bus.cmd_err = cmd_err_q;
`endif

    assign bus.rd_valid = (count_q != 2'd0);
    assign bus.rd_data  = fifo_q[rptr_q];
    assign bus.busy     = (state_q != IDLE);
    assign state_o      = state_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        inflight_d    = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = '0;
        bus.ram_addr  = addr_q;
`ifdef BRM_WRAP_CHK_EN
        cmd_err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
`ifdef BRM_WRAP_CHK_EN
                    if (crossing) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        addr_d  = bus.cmd_addr;
                        len_d   = bus.cmd_len;
                        cnt_d   = 4'd0;
                        state_d = bus.cmd_write ? WRITE : READ;
                    end
`else
                    addr_d  = bus.cmd_addr;
                    len_d   = bus.cmd_len;
                    cnt_d   = 4'd0;
                    state_d = bus.cmd_write ? WRITE : READ;
`endif
                end
            end
            WRITE: begin
                bus.wr_ready = 1'b1;
                if (bus.wr_valid) begin
                    bus.ram_we    = 1'b1;
                    bus.ram_wdata = bus.wr_data;
                    addr_d        = addr_q + 1'b1;
                    cnt_d         = cnt_q + 4'd1;
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                if (credit_ok) begin
                    inflight_d = 1'b1;
                    addr_d     = addr_q + 1'b1;
                    cnt_d      = cnt_q + 4'd1;
                    if (cnt_q == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The final read lands in the FIFO at the end of this cycle.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            count_q    <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
`ifdef BRM_WRAP_CHK_EN
            cmd_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            if (push) begin
                fifo_q[wptr_q] <= bus.ram_q;
            end
`ifdef BRM_WRAP_CHK_EN
            cmd_err_q  <= cmd_err_d;
`endif
        end
    end
endmodule
